// File: rtl/udp_payload_store.sv
// udp_payload_store
// Payload RAM and length selector sitting between the UDP RX and TX engines.
// After reset the block writes a default message into the RAM, one word per
// cycle, fetched from an external lookup through def_idx/def_word. Once that
// is done it accepts received payload words and frame lengths. It also gives
// the TX engine a registered read port and the UDP/IP lengths to send, chosen
// by mode.
//
// Ports
//   e_rxc, reset        single clock, synchronous active-high reset
//   mode                00 echo-if-received, 01 default, 10 echo, 11 reload
//   def_idx / def_word  default-message lookup (def_word is combinational)
//   rx_wr_*             RX payload word write strobe/address/data
//   rx_done             one-cycle frame-complete pulse with rx_*_length valid
//   tx_busy             TX is reading; RAM contents and lengths are frozen
//   rd_addr / rd_data   TX read port, one cycle of latency, read-first
//   tx_*_length         registered lengths to transmit
//   init_done, have_rx  status flags
//   drop_cnt            saturating count of cycles that dropped RX events
//   state_dbg           current FSM state (0 = INIT, 1 = READY)
//
// Handshake: rx_wr_valid and rx_done are plain strobes with no back-pressure.
// An event that arrives while loading the defaults, or while tx_busy is high,
// is discarded and counted in drop_cnt instead of being stalled.
module udp_payload_store #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int DEF_WORDS = 7,
  parameter int DEF_BASE  = 0,
  parameter int UDP_HDR   = 8,
  parameter int IP_HDR    = 20
) (
  input  logic              e_rxc,
  input  logic              reset,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] def_idx,
  input  logic [DATA_W-1:0] def_word,
  input  logic              rx_wr_valid,
  input  logic [ADDR_W-1:0] rx_wr_addr,
  input  logic [DATA_W-1:0] rx_wr_data,
  input  logic              rx_done,
  input  logic [15:0]       rx_data_length,
  input  logic [15:0]       rx_total_length,
  input  logic              tx_busy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [15:0]       tx_data_length,
  output logic [15:0]       tx_total_length,
  output logic              init_done,
  output logic              have_rx,
  output logic [7:0]        drop_cnt,
  output logic              state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [15:0] DEF_UDP = 16'(UDP_HDR + DEF_WORDS * (DATA_W / 8));
  localparam logic [15:0] DEF_IP  = 16'(IP_HDR) + DEF_UDP;
  localparam logic [ADDR_W-1:0] DEF_BASE_A = ADDR_W'(DEF_BASE);
  localparam logic [ADDR_W-1:0] DEF_LAST   = ADDR_W'(DEF_WORDS - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   def_idx_q;
  logic                init_done_q;
  logic                have_rx_q;
  logic [7:0]          drop_cnt_q;
  logic [15:0]         held_udp_q;
  logic [15:0]         held_ip_q;
  logic [15:0]         tx_udp_q;
  logic [15:0]         tx_ip_q;
  logic [1:0]          mode_prev_q;
  logic                reload_pend_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_init;
  logic                reload_req;
  logic                reload_go;
  logic                drop_evt;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [15:0]         sel_udp_d;
  logic [15:0]         sel_ip_d;

  always_comb begin
    in_init = (state_q == ST_INIT);

    // A reload is armed by the edge into mode 11. While TX is busy it waits
    // in reload_pend_q, and it is forgotten if mode leaves 11 in the meantime.
    reload_req = (mode == 2'b11) && ((mode_prev_q != 2'b11) || reload_pend_q);
    reload_go  = !in_init && !tx_busy && reload_req;

    // One count per cycle, however many events were lost in it.
    drop_evt = (rx_wr_valid || rx_done) && (in_init || tx_busy);

    // Single write port: the default loader owns it during INIT.
    wr_en   = 1'b0;
    wr_addr = rx_wr_addr;
    wr_data = rx_wr_data;
    if (in_init) begin
      wr_en   = 1'b1;
      wr_addr = DEF_BASE_A + def_idx_q;
      wr_data = def_word;
    end else if (rx_wr_valid && !tx_busy) begin
      wr_en = 1'b1;
    end

    sel_udp_d = DEF_UDP;
    sel_ip_d  = DEF_IP;
    if (!in_init && have_rx_q && (mode == 2'b00 || mode == 2'b10)) begin
      sel_udp_d = held_udp_q;
      sel_ip_d  = held_ip_q;
    end
  end

  // RAM array has no reset, so its contents survive a reset.
  always_ff @(posedge e_rxc) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge e_rxc) begin
    if (reset) begin
      state_q       <= ST_INIT;
      def_idx_q     <= '0;
      init_done_q   <= 1'b0;
      have_rx_q     <= 1'b0;
      drop_cnt_q    <= '0;
      held_udp_q    <= DEF_UDP;
      held_ip_q     <= DEF_IP;
      tx_udp_q      <= DEF_UDP;
      tx_ip_q       <= DEF_IP;
      mode_prev_q   <= 2'b00;
      reload_pend_q <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      mode_prev_q   <= mode;
      reload_pend_q <= reload_req && !in_init && !reload_go;
      // Read-first: a write to the same address lands after this sample.
      rd_data_q     <= mem[rd_addr];

      if (drop_evt && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;

      if (in_init || !tx_busy) begin
        tx_udp_q <= sel_udp_d;
        tx_ip_q  <= sel_ip_d;
      end

      case (state_q)
        ST_INIT: begin
          if (def_idx_q == DEF_LAST) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
            def_idx_q   <= '0;
          end else begin
            def_idx_q <= def_idx_q + 1'b1;
          end
        end
        ST_READY: begin
          if (rx_done && !tx_busy) begin
            held_udp_q <= rx_data_length;
            held_ip_q  <= rx_total_length;
            have_rx_q  <= 1'b1;
          end
          if (reload_go) begin
            state_q     <= ST_INIT;
            init_done_q <= 1'b0;
            have_rx_q   <= 1'b0;
            def_idx_q   <= '0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign def_idx         = def_idx_q;
  assign rd_data         = rd_data_q;
  assign tx_data_length  = tx_udp_q;
  assign tx_total_length = tx_ip_q;
  assign init_done       = init_done_q;
  assign have_rx         = have_rx_q;
  assign drop_cnt        = drop_cnt_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_udp_payload_store.sv
// Bench for udp_payload_store: directed steps plus a randomized phase, checked
// against a reference held as an expected RAM image and expected flags/lengths.
module tb_udp_payload_store;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 32;
  localparam int DEF_WORDS = 7;
  localparam logic [15:0] DEF_UDP = 16'd36;  // 8 + 7*4
  localparam logic [15:0] DEF_IP  = 16'd56;  // 20 + 36

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        mode = 2'b00;
  logic [ADDR_W-1:0] def_idx;
  logic [DATA_W-1:0] def_word;
  logic              rx_wr_valid = 1'b0;
  logic [ADDR_W-1:0] rx_wr_addr = '0;
  logic [DATA_W-1:0] rx_wr_data = '0;
  logic              rx_done = 1'b0;
  logic [15:0]       rx_data_length = '0;
  logic [15:0]       rx_total_length = '0;
  logic              tx_busy = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic [15:0]       tx_data_length;
  logic [15:0]       tx_total_length;
  logic              init_done;
  logic              have_rx;
  logic [7:0]        drop_cnt;
  logic              state_dbg;

  // External default-message lookup: word = base + index.
  logic [DATA_W-1:0] def_base_v = 32'h48454C4C;
  always_comb def_word = def_base_v + 32'(def_idx);

  udp_payload_store dut (
    .e_rxc(clk), .reset(reset), .mode(mode), .def_idx(def_idx), .def_word(def_word),
    .rx_wr_valid(rx_wr_valid), .rx_wr_addr(rx_wr_addr), .rx_wr_data(rx_wr_data),
    .rx_done(rx_done), .rx_data_length(rx_data_length), .rx_total_length(rx_total_length),
    .tx_busy(tx_busy), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data_length(tx_data_length), .tx_total_length(tx_total_length),
    .init_done(init_done), .have_rx(have_rx), .drop_cnt(drop_cnt), .state_dbg(state_dbg)
  );

  // scoreboard state
  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_mem [0:511];
  bit                exp_vld [0:511];
  logic [DATA_W-1:0] exp_q[$];
  int                drops_total = 0;
  logic              exp_have = 1'b0;
  logic [15:0]       held_u, held_i;
  logic [15:0]       exp_u = DEF_UDP;
  logic [15:0]       exp_i = DEF_IP;

  // driver / check tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_drop();
    return (drops_total > 255) ? 32'd255 : 32'(drops_total);
  endfunction

  task automatic chk_lens(input string tag);
    chk({tag, "_udp"}, 32'(tx_data_length), 32'(exp_u));
    chk({tag, "_ip"}, 32'(tx_total_length), 32'(exp_i));
  endtask

  task automatic read_chk(input int a, input string tag);
    rd_addr = ADDR_W'(a);
    exp_q.push_back(exp_mem[a]);
    cycle();
    chk(tag, rd_data, exp_q.pop_front());
  endtask

  task automatic load_defaults();
    for (int i = 0; i < DEF_WORDS; i++) begin
      exp_mem[i] = def_base_v + 32'(i);
      exp_vld[i] = 1'b1;
    end
  endtask

  // Reset is released before this is called; edges 1..7 carry the writes.
  task automatic run_init(input string tag);
    for (int i = 1; i <= DEF_WORDS; i++) begin
      cycle();
      if (i < DEF_WORDS) begin
        chk({tag, "_busy_init_done"}, 32'(init_done), 32'd0);
        chk({tag, "_def_idx"}, 32'(def_idx), 32'(i));
      end else begin
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
        chk({tag, "_def_idx_wrap"}, 32'(def_idx), 32'd0);
      end
    end
  endtask

  task automatic set_exp_lens_from_mode();
    if (mode == 2'b01 || mode == 2'b11 || !exp_have) begin
      exp_u = DEF_UDP; exp_i = DEF_IP;
    end else begin
      exp_u = held_u; exp_i = held_i;
    end
  endtask

  initial begin
    logic [DATA_W-1:0] d, old;
    bit busy, v, dn;
    int a;
    for (int i = 0; i < 512; i++) exp_vld[i] = 1'b0;

    // ---- Test 1: reset and default preload
    cycle();
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_have_rx", 32'(have_rx), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_def_idx", 32'(def_idx), 32'd0);
    chk_lens("rst_len");
    reset = 1'b0;
    for (int i = 1; i <= DEF_WORDS; i++) begin
      // Simultaneous strobe and done during INIT: one dropped cycle.
      if (i == 3) begin rx_wr_valid = 1'b1; rx_done = 1'b1; drops_total++; end
      cycle();
      rx_wr_valid = 1'b0; rx_done = 1'b0;
      if (i < DEF_WORDS) chk("t1_init_done_low", 32'(init_done), 32'd0);
      else chk("t1_init_done_high", 32'(init_done), 32'd1);
    end
    load_defaults();
    chk("t1_drop", 32'(drop_cnt), exp_drop());
    chk_lens("t1_len");
    for (int i = 0; i < DEF_WORDS; i++) read_chk(i, "t1_mem");

    // ---- Test 2: echo path
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      rx_wr_valid = 1'b1; rx_wr_addr = ADDR_W'(i); rx_wr_data = d;
      cycle();
      exp_mem[i] = d;
    end
    rx_wr_valid = 1'b0;
    rx_done = 1'b1; rx_data_length = 16'd20; rx_total_length = 16'd40;
    cycle();
    rx_done = 1'b0;
    chk("t2_have_rx", 32'(have_rx), 32'd1);
    chk_lens("t2_len_same_cycle");
    exp_have = 1'b1; held_u = 16'd20; held_i = 16'd40;
    cycle();
    set_exp_lens_from_mode();
    chk_lens("t2_len_echo");
    read_chk(1, "t2_rd1");
    // read-first: same-address read and write in one cycle
    old = exp_mem[1]; d = $urandom;
    rd_addr = ADDR_W'(1); rx_wr_valid = 1'b1; rx_wr_addr = ADDR_W'(1); rx_wr_data = d;
    cycle();
    rx_wr_valid = 1'b0;
    chk("t2_read_first_old", rd_data, old);
    exp_mem[1] = d;
    read_chk(1, "t2_read_first_new");

    // ---- Test 3: drops while TX busy, lengths frozen
    tx_busy = 1'b1; mode = 2'b01;
    rx_wr_valid = 1'b1; rx_wr_addr = ADDR_W'(0); rx_wr_data = $urandom;
    cycle(); drops_total++;
    rx_wr_addr = ADDR_W'(1); rx_wr_data = $urandom;
    rx_done = 1'b1; rx_data_length = 16'd100; rx_total_length = 16'd120;
    cycle(); drops_total++;
    rx_wr_valid = 1'b0; rx_done = 1'b0;
    chk("t3_drop", 32'(drop_cnt), exp_drop());
    chk("t3_have_rx", 32'(have_rx), 32'd1);
    chk_lens("t3_len_frozen");
    tx_busy = 1'b0;
    cycle();
    set_exp_lens_from_mode();
    chk_lens("t3_len_mode01");
    mode = 2'b00;
    cycle();
    set_exp_lens_from_mode();
    chk_lens("t3_len_held_unchanged");
    read_chk(0, "t3_mem0");
    read_chk(1, "t3_mem1");

    // ---- Randomized phase (modes 00/01/10)
    for (int n = 0; n < 80; n++) begin
      busy = 1'($urandom_range(0, 1));
      v    = 1'($urandom_range(0, 1));
      dn   = ($urandom_range(0, 3) == 0);
      a    = $urandom_range(8, 63);
      d    = $urandom;
      tx_busy = busy; rx_wr_valid = v; rx_wr_addr = ADDR_W'(a); rx_wr_data = d;
      rx_done = dn; rx_data_length = 16'($urandom); rx_total_length = 16'($urandom);
      mode = 2'($urandom_range(0, 2));
      // Selection uses the flags/lengths held before this edge.
      if (!busy) set_exp_lens_from_mode();
      if (!busy && v) begin exp_mem[a] = d; exp_vld[a] = 1'b1; end
      if (!busy && dn) begin exp_have = 1'b1; held_u = rx_data_length; held_i = rx_total_length; end
      if (busy && (v || dn)) drops_total++;
      cycle();
      chk("rnd_have_rx", 32'(have_rx), 32'(exp_have));
      chk("rnd_drop", 32'(drop_cnt), exp_drop());
      chk_lens("rnd_len");
    end
    tx_busy = 1'b0; rx_wr_valid = 1'b0; rx_done = 1'b0; mode = 2'b00;
    set_exp_lens_from_mode();
    cycle();
    chk_lens("rnd_len_final");
    for (int i = 8; i < 64; i++) if (exp_vld[i]) read_chk(i, "rnd_mem");

    // ---- Test 4: mode 01 defaults, aborted reload, real reload
    mode = 2'b01;
    cycle();
    set_exp_lens_from_mode();
    chk_lens("t4_len_mode01");
    tx_busy = 1'b1; mode = 2'b11;
    cycle();
    mode = 2'b00;
    cycle();
    tx_busy = 1'b0;
    cycle();
    set_exp_lens_from_mode();
    chk("t4_abort_init_done", 32'(init_done), 32'd1);
    chk_lens("t4_abort_len");
    mode = 2'b01;
    cycle();
    tx_busy = 1'b1; mode = 2'b11;
    cycle();
    cycle();
    chk("t4_busy_no_reload", 32'(init_done), 32'd1);
    def_base_v = $urandom;
    tx_busy = 1'b0;
    cycle();
    exp_have = 1'b0; exp_u = DEF_UDP; exp_i = DEF_IP;
    chk("t4_reload_init_done", 32'(init_done), 32'd0);
    chk("t4_reload_have_rx", 32'(have_rx), 32'd0);
    chk("t4_reload_def_idx", 32'(def_idx), 32'd0);
    chk_lens("t4_reload_len");
    run_init("t4");
    load_defaults();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_hold11_no_retrigger", 32'(init_done), 32'd1);
    end
    mode = 2'b10;
    cycle();
    chk_lens("t4_mode10_len");
    for (int i = 0; i < DEF_WORDS; i++) read_chk(i, "t4_mem_restored");

    // ---- Test 5: saturation, then reset mid-READY and mid-INIT
    tx_busy = 1'b1; rx_wr_valid = 1'b1; rx_wr_addr = ADDR_W'(5);
    for (int i = 0; i < 300; i++) begin
      rx_wr_data = $urandom;
      cycle();
      drops_total++;
    end
    rx_wr_valid = 1'b0; tx_busy = 1'b0;
    chk("t5_drop_sat", 32'(drop_cnt), exp_drop());
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5_rst_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_mid_init_idx", 32'(def_idx), 32'd3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5_rst_def_idx", 32'(def_idx), 32'd0);
    chk("t5_rst_init_done", 32'(init_done), 32'd0);
    chk("t5_rst_have_rx", 32'(have_rx), 32'd0);
    chk("t5_rst_rd_data", rd_data, 32'd0);
    chk_lens("t5_rst_len");
    def_base_v = $urandom;
    run_init("t5");
    load_defaults();
    for (int i = 0; i < DEF_WORDS; i++) read_chk(i, "t5_mem");

    // ---- report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
